rng_stream: RTL
===============

Name: rng_stream

Overview:
- Parametrised successor to the 32-bit free-running rng.
- Contains a xorshift32 core with runtime seed loading and an optional bounded-range mode that uses rejection sampling.
- Output is a valid/ready stream, so consumers can draw numbers at their own rate.
- Consumers are the game-logic blocks (terrain/object placement, AI choices) that need reproducible, uniformly distributed values in [0, bound).

Parameters:
WIDTH, 16, output word width in bits; legal range 1..32; output = low WIDTH bits of the masked candidate.
SEED_DEFAULT, 32'hACE1_2345, state loaded at reset; also substituted whenever a zero seed is loaded; must be non-zero.

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous active-high reset
en_in  input  1  generator enable; when low, state and outputs freeze
seed_load_in  input  1  one-cycle pulse: load seed_in into the state
seed_in  input  32  seed value
bound_in  input  WIDTH  range bound; 0 = raw mode (full WIDTH bits), else output in [0, bound_in-1]
ready_in  input  1  consumer accepts data_out this cycle
valid_out  output  1  data_out holds a valid sample
data_out  output  WIDTH  random sample
rejects_out  output  16  saturating count of rejected candidates since reset or seed load

Behaviour:
- Reset (async assert, released synchronously by the clock) produces:
  - state = SEED_DEFAULT
  - valid_out = 0, data_out = 0, rejects_out = 0
  - FSM = FILL
- Step function xs(x): x ^= x<<13; x ^= x>>17; x ^= x<<5 (32-bit, in that order). Example: xs(1) = 32'h0004_2021.
- mask(B):
  - B = 0: all ones.
  - B = 1: zero.
  - Otherwise: 2^k - 1, where k = bit length of (B-1).
- Candidate: cand = xs(state)[WIDTH-1:0] & mask(bound_in).
- Acceptance: cand is accepted if bound_in == 0 or cand < bound_in.
- bound_in is sampled every step and is not latched. Changing it while valid_out = 1 does not alter the held data_out.
- A "step" is one clock edge with en_in = 1 in which state <= xs(state) and the candidate is evaluated.
- FSM FILL (valid_out = 0):
  - Each enabled cycle performs a step.
  - On accept: data_out <= cand, valid_out <= 1, go to HOLD.
  - On reject: rejects_out increments (saturates at 16'hFFFF), remain in FILL.
- FSM HOLD (valid_out = 1):
  - ready_in = 0: state, data_out and valid_out are held (backpressure; no steps).
  - ready_in = 1 and en_in = 1: perform a step in the same cycle.
    - On accept: new data_out, valid_out stays 1 (back-to-back, 1 sample/cycle).
    - On reject: valid_out <= 0, go to FILL.
  - ready_in = 1 and en_in = 0: valid_out <= 0, go to FILL (sample consumed, no step).
- Latency: the first sample is valid on the first enabled edge after reset release when accepted (raw mode always accepts, so always latency 1).
- Reject probability per step is < 1/2, so expected steps per sample are < 2. There is no step bound; a bench must not rely on one.
- seed_load_in has highest priority (after reset):
  - state <= (seed_in == 0) ? SEED_DEFAULT : seed_in
  - valid_out <= 0, rejects_out <= 0, FSM = FILL
  - No step occurs in the load cycle. An un-consumed sample is discarded.
- en_in = 0 in FILL: nothing changes. ready_in is ignored while valid_out = 0.
- Zero state is unreachable: xs is a bijection with 0 as a fixed point, and 0 is never loaded.
- Reset mid-operation returns to the reset values immediately (async), regardless of FSM state or pending handshake.

Test Plan:
- Raw first output: WIDTH=32, SEED_DEFAULT=1, bound 0, en=1, ready=1, rst released -> after 1st edge valid_out=1, data_out=32'h0004_2021; subsequent data matches a software xorshift32 model each cycle.
- Backpressure: ready=0 for 10 cycles with valid_out=1 -> data_out and internal sequence unchanged; on ready=1, the next sample equals the model's next value (no skipped values).
- Bounded mode: WIDTH=16, bound=5, 10k handshakes -> every data_out in 0..4, each value 1600..2400 times; rejects_out equals the model's reject count. bound=1 -> data_out always 0 with zero rejects.
- Seed load: seed_load_in with seed_in=1 while in HOLD -> valid_out=0 next cycle, rejects_out=0, next sample 32'h0004_2021 (WIDTH=32). seed_in=0 -> sequence identical to a SEED_DEFAULT reset.
- Enable/reset: en_in=0 for 8 cycles -> no state or output change. rst_in pulsed asynchronously mid-HOLD (between edges) -> valid_out and data_out go to 0 before the next edge, and the sequence restarts from SEED_DEFAULT.

Source files
------------

// File: rtl/rng_stream.sv
// rng_stream: xorshift32 random number source with a valid/ready output stream.
//
// A 32-bit xorshift state advances once per "step". Each step produces a
// candidate, which is the low WIDTH bits of the new state ANDed with a mask
// derived from bound_in. In bounded mode (bound_in != 0) a candidate is
// accepted only if it is below bound_in, which is rejection sampling. Accepted
// candidates are presented on a valid/ready stream. The number of rejected
// candidates is counted and saturates.
//
// Parameters:
//   WIDTH        - output word width, 1..32
//   SEED_DEFAULT - state after reset; also used when a zero seed is loaded
//                  (must be non-zero)
//
// Ports:
//   clk_in       - clock, rising edge
//   rst_in       - asynchronous active-high reset
//   en_in        - generator enable; when low, no steps are taken
//   seed_load_in - one-cycle pulse: load seed_in, drop any pending sample
//   seed_in      - seed value (0 selects SEED_DEFAULT)
//   bound_in     - range bound; 0 = raw WIDTH-bit output, else [0, bound_in-1]
//   ready_in     - consumer takes data_out this cycle
//   valid_out    - data_out holds a sample
//   data_out     - random sample
//   rejects_out  - saturating count of rejected candidates since reset/load
module rng_stream #(
  parameter int unsigned WIDTH        = 16,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2345
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             seed_load_in,
  input  logic [31:0]      seed_in,
  input  logic [WIDTH-1:0] bound_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic [15:0]      rejects_out
);

  typedef enum logic {
    FILL,
    HOLD
  } fsm_t;

  fsm_t             fsm;
  logic [31:0]      state;
  logic [31:0]      nxt;
  logic [31:0]      seed_eff;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cand;
  logic             accept;
  logic [15:0]      rejects_inc;

  // One xorshift32 step: shifts 13, 17, 5, applied in that order.
  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign nxt = xs(state);

  // The smallest all-ones mask that covers bound_in-1 is built by smearing the
  // highest set bit of (bound_in-1) downwards. bound_in == 1 gives 0, so the
  // only candidate is 0. bound_in == 0 selects raw mode, which uses all ones.
  always_comb begin
    logic [WIDTH-1:0] m;
    m = bound_in - WIDTH'(1);
    for (int unsigned i = 1; i < WIDTH; i = i * 2) begin
      m = m | (m >> i);
    end
    mask = (bound_in == '0) ? '1 : m;
  end

  assign cand        = nxt[WIDTH-1:0] & mask;
  assign accept      = (bound_in == '0) || (cand < bound_in);
  assign seed_eff    = (seed_in == '0) ? SEED_DEFAULT : seed_in;
  assign rejects_inc = (rejects_out == '1) ? rejects_out : rejects_out + 16'd1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fsm         <= FILL;
      state       <= SEED_DEFAULT;
      valid_out   <= 1'b0;
      data_out    <= '0;
      rejects_out <= '0;
    end else if (seed_load_in) begin
      // A load discards any held sample and takes no step in this cycle.
      fsm         <= FILL;
      state       <= seed_eff;
      valid_out   <= 1'b0;
      rejects_out <= '0;
    end else begin
      case (fsm)
        FILL: begin
          if (en_in) begin
            state <= nxt;
            if (accept) begin
              data_out  <= cand;
              valid_out <= 1'b1;
              fsm       <= HOLD;
            end else begin
              rejects_out <= rejects_inc;
            end
          end
        end
        HOLD: begin
          // With ready_in low, everything holds (backpressure). When the
          // sample is consumed and enable is high, the replacement is drawn
          // in the same cycle, so the stream can deliver one sample per clock.
          if (ready_in) begin
            if (en_in) begin
              state <= nxt;
              if (accept) begin
                data_out <= cand;
              end else begin
                rejects_out <= rejects_inc;
                valid_out   <= 1'b0;
                fsm         <= FILL;
              end
            end else begin
              valid_out <= 1'b0;
              fsm       <= FILL;
            end
          end
        end
        default: begin
          fsm       <= FILL;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
